pong_sound: RTL

Sound-effect sequencer for the Pong FPGA; consumes the 12-bit `sound_sel` word that the SPI data decode produces and drives the single-bit `audio_out` pin to the audio amplifier. `sound_sel` changes at most once per monitor refresh and comes from the vsync-clocked SPI receive path. The block therefore resynchronises it, detects new events by a sequence tag, arbitrates by priority, and plays timed square-wave notes from the board clock.

---
 rtl/pong_sound.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pong_sound.sv
// Sound-effect sequencer: resynchronises the SPI event word, detects new tagged events,
// arbitrates by code priority and plays timed square-wave notes. Score jingle: PONG_SOUND_JINGLE_EN.
module pong_sound #(
  parameter int unsigned CLK_HZ = 40_000_000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [11:0] sound_sel,
  output logic        audio_out,
  output logic        busy,
  output logic [1:0]  active_code
);

  localparam int unsigned MS_CYC     = CLK_HZ / 1000;
  localparam int unsigned HALF_220   = CLK_HZ / 440;
  localparam int unsigned HALF_440   = CLK_HZ / 880;
  localparam int unsigned HALF_660   = CLK_HZ / 1320;
  localparam int unsigned TONE_W     = $clog2(HALF_220 + 1);
  localparam int unsigned PRE_W      = $clog2(MS_CYC + 1);
  localparam int unsigned MS_W       = 8;
  localparam int unsigned DUR_WALL   = 40;
  localparam int unsigned DUR_PADDLE = 80;
  localparam int unsigned DUR_SCORE  = 150;
`ifdef PONG_SOUND_JINGLE_EN
  localparam int unsigned HALF_330   = CLK_HZ / 660;
  localparam int unsigned DUR_GAP    = 20;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef PONG_SOUND_JINGLE_EN
    GAP  = 2'd2,
`endif
    NOTE = 2'd1
  } state_t;

  state_t             state, state_d;
  logic [11:0]        s1, s2, s3;
  logic [7:0]         last_tag;
  logic [TONE_W-1:0]  tone_cnt, tone_d;
  logic [PRE_W-1:0]   pre_cnt, pre_d;
  logic [MS_W-1:0]    ms_cnt, ms_d;
  logic [1:0]         code_d;
  logic               audio_d, busy_d;
  logic               new_tag, start_new, ms_tick, note_done;
  logic [TONE_W-1:0]  cur_half;
  logic [MS_W-1:0]    cur_dur;
`ifdef PONG_SOUND_JINGLE_EN
  logic               note_two, note_two_d, gap_done;
`endif

  // Event detection: a stable word whose tag differs from the last one seen
  always_comb begin
    new_tag   = (s2 == s3) && (s2[11:4] != last_tag);
    start_new = new_tag && (s2[1:0] != 2'd0) && (s2[1:0] >= active_code);
  end

  // Half-period and duration of the note currently selected
  always_comb begin
    cur_half = TONE_W'(HALF_440);
    cur_dur  = MS_W'(DUR_PADDLE);
    case (active_code)
      2'd1: begin
        cur_half = TONE_W'(HALF_220);
        cur_dur  = MS_W'(DUR_WALL);
      end
      2'd3: begin
        cur_half = TONE_W'(HALF_660);
        cur_dur  = MS_W'(DUR_SCORE);
`ifdef PONG_SOUND_JINGLE_EN
        if (note_two) cur_half = TONE_W'(HALF_330);
`endif
      end
      default: ;
    endcase
    ms_tick   = (pre_cnt == PRE_W'(MS_CYC - 1));
    note_done = ms_tick && (ms_cnt == cur_dur - MS_W'(1));
`ifdef PONG_SOUND_JINGLE_EN
    gap_done  = ms_tick && (ms_cnt == MS_W'(DUR_GAP - 1));
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state;
    code_d  = active_code;
    audio_d = audio_out;
    tone_d  = tone_cnt;
    pre_d   = ms_tick ? '0 : pre_cnt + PRE_W'(1);
    ms_d    = ms_tick ? ms_cnt + MS_W'(1) : ms_cnt;
`ifdef PONG_SOUND_JINGLE_EN
    note_two_d = note_two;
`endif
    case (state)
      IDLE: begin
        audio_d = 1'b0;
        tone_d  = '0;
        pre_d   = '0;
        ms_d    = '0;
      end
      NOTE: begin
        if (tone_cnt == cur_half - TONE_W'(1)) begin
          tone_d  = '0;
          audio_d = ~audio_out;
        end else begin
          tone_d  = tone_cnt + TONE_W'(1);
        end
        if (note_done) begin
          audio_d = 1'b0;
          tone_d  = '0;
          pre_d   = '0;
          ms_d    = '0;
          state_d = IDLE;
          code_d  = 2'd0;
`ifdef PONG_SOUND_JINGLE_EN
          if (active_code == 2'd3 && !note_two) begin
            state_d = GAP;
            code_d  = active_code;
          end
`endif
        end
      end
`ifdef PONG_SOUND_JINGLE_EN
      GAP: begin
        audio_d = 1'b0;
        if (gap_done) begin
          state_d    = NOTE;
          note_two_d = 1'b1;
          audio_d    = 1'b1;
          tone_d     = '0;
          pre_d      = '0;
          ms_d       = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        code_d  = 2'd0;
        audio_d = 1'b0;
      end
    endcase
    // A qualifying new event overrides everything, including a same-edge expiry
    if (start_new) begin
      state_d = NOTE;
      code_d  = s2[1:0];
      audio_d = 1'b1;
      tone_d  = '0;
      pre_d   = '0;
      ms_d    = '0;
`ifdef PONG_SOUND_JINGLE_EN
      note_two_d = 1'b0;
`endif
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      last_tag    <= '0;
      tone_cnt    <= '0;
      pre_cnt     <= '0;
      ms_cnt      <= '0;
      active_code <= 2'd0;
      audio_out   <= 1'b0;
      busy        <= 1'b0;
`ifdef PONG_SOUND_JINGLE_EN
      note_two    <= 1'b0;
`endif
    end else begin
      s1          <= sound_sel;
      s2          <= s1;
      s3          <= s2;
      if (new_tag) last_tag <= s2[11:4];
      state       <= state_d;
      tone_cnt    <= tone_d;
      pre_cnt     <= pre_d;
      ms_cnt      <= ms_d;
      active_code <= code_d;
      audio_out   <= audio_d;
      busy        <= busy_d;
`ifdef PONG_SOUND_JINGLE_EN
      note_two    <= note_two_d;
`endif
    end
  end

endmodule
